// File: rtl/regfile_write_sched.sv
// Write-port owner for the 32x32 register file: clears registers 1..NUM_REGS-1 after reset
// or on request, then shares the single write port between requesters A and B round-robin.

module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [DATA_W-1:0] mem_r [NUM_REGS];

  // Single write port; register 0 is hardwired to zero and never stored.
  always_ff @(posedge Clk) begin
    if (RegWrite && (WriteRegister != '0)) begin
      mem_r[WriteRegister] <= WriteData;
    end
  end

  // Two asynchronous read ports.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 == '0) begin
      ReadData1 = '0;
    end else begin
      ReadData1 = mem_r[ReadRegister1];
    end
    if (ReadRegister2 == '0) begin
      ReadData2 = '0;
    end else begin
      ReadData2 = mem_r[ReadRegister2];
    end
  end

endmodule

module regfile_write_sched #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ClearReq,
  input  logic              ReqA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DataA,
  output logic              GntA,
  input  logic              ReqB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataB,
  output logic              GntB,
  output logic              Ready,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic              PTR_A      = 1'b0;
  localparam logic              PTR_B      = 1'b1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              rr_ptr_r;
  logic [ADDR_W-1:0] write_register_r;
  logic [DATA_W-1:0] write_data_r;
  logic              reg_write_r;

  logic              run_s;
  logic              gnt_a_s;
  logic              gnt_b_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;

  // Grant decode: nothing is granted while clearing or while a clear is being requested.
  always_comb begin
    run_s   = (state_r == ST_RUN);
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (run_s && !ClearReq) begin
      if (ReqA && ReqB) begin
        gnt_a_s = (rr_ptr_r == PTR_A);
        gnt_b_s = (rr_ptr_r == PTR_B);
      end else begin
        gnt_a_s = ReqA;
        gnt_b_s = ReqB;
      end
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // Winner address/data mux feeding the write-port registers.
  always_comb begin
    win_addr_s = AddrA;
    win_data_s = DataA;
    if (gnt_b_s) begin
      win_addr_s = AddrB;
      win_data_s = DataB;
    end else begin
      win_addr_s = AddrA;
      win_data_s = DataA;
    end
  end

  // Sequencer: clear sweep, then arbitrated writes; all write-port signals registered here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r          <= ST_CLEAR;
      cnt_r            <= FIRST_ADDR;
      rr_ptr_r         <= PTR_A;
      write_register_r <= '0;
      write_data_r     <= '0;
      reg_write_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          write_register_r <= cnt_r;
          write_data_r     <= '0;
          reg_write_r      <= 1'b1;
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_RUN;
            cnt_r   <= FIRST_ADDR;
          end else begin
            cnt_r <= cnt_r + FIRST_ADDR;
          end
        end
        ST_RUN: begin
          if (ClearReq) begin
            state_r     <= ST_CLEAR;
            cnt_r       <= FIRST_ADDR;
            reg_write_r <= 1'b0;
          end else if (gnt_a_s || gnt_b_s) begin
            write_register_r <= win_addr_s;
            write_data_r     <= win_data_s;
            // A write aimed at register 0 is consumed but never reaches the array.
            reg_write_r      <= (win_addr_s != '0);
            rr_ptr_r         <= gnt_a_s ? PTR_B : PTR_A;
          end else begin
            reg_write_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          cnt_r       <= FIRST_ADDR;
          reg_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign GntA          = gnt_a_s;
  assign GntB          = gnt_b_s;
  assign Ready         = run_s;
  assign WriteRegister = write_register_r;
  assign WriteData     = write_data_r;
  assign RegWrite      = reg_write_r;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed scenarios followed by randomized traffic checked against a queue/array reference model.

module tb_regfile_write_sched;

  logic        Clk = 1'b0;
  logic        Reset_n, ClearReq, ReqA, ReqB, GntA, GntB, Ready, RegWrite;
  logic [4:0]  AddrA, AddrB, WriteRegister, rd_addr1, rd_addr2;
  logic [31:0] DataA, DataB, WriteData, rd_data1, rd_data2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          sweep_q[$];
  logic [31:0] mem_m [32];
  bit          next_is_a, ra, rb, clr, run, ega, egb;
  logic [4:0]  aa, ab, cur_wr, e_wr;
  logic [31:0] da, db, cur_wd, e_wd;
  bit          cur_we, e_we;

  always #5 Clk = ~Clk;

  regfile_write_sched dut (
    .Clk(Clk), .Reset_n(Reset_n), .ClearReq(ClearReq),
    .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .GntA(GntA),
    .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .GntB(GntB),
    .Ready(Ready), .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  regfile u_rf (
    .Clk(Clk), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd_data1), .ReadData2(rd_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
    rd_addr1 = a;
    #1;
    chk(tag, rd_data1, exp);
  endtask

  task automatic sweep_chk(input string tag);
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk({tag, "_gnt"}, {30'd0, GntA, GntB}, 32'd0);
      chk({tag, "_rdy"}, {31'd0, Ready}, 32'd0);
      step();
      chk({tag, "_we"}, {31'd0, RegWrite}, 32'd1);
      chk({tag, "_wr"}, {27'd0, WriteRegister}, 32'(i));
      chk({tag, "_wd"}, WriteData, 32'd0);
    end
  endtask

  initial begin
    Reset_n = 1'b0; ClearReq = 1'b0;
    ReqA = 1'b1; AddrA = 5'd3; DataA = 32'd1;
    ReqB = 1'b1; AddrB = 5'd4; DataB = 32'd2;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;

    // reset state, with requests asserted that must not be granted
    step(); step(); #1;
    chk("rst_we", {31'd0, RegWrite}, 32'd0);
    chk("rst_wr", {27'd0, WriteRegister}, 32'd0);
    chk("rst_wd", WriteData, 32'd0);
    chk("rst_rdy", {31'd0, Ready}, 32'd0);
    chk("rst_gnt", {30'd0, GntA, GntB}, 32'd0);
    ReqA = 1'b0; ReqB = 1'b0;
    Reset_n = 1'b1;

    // 1: power-on sweep, then idle
    sweep_chk("t1");
    #1;
    chk("t1_rdy_up", {31'd0, Ready}, 32'd1);
    step();
    chk("t1_idle_we", {31'd0, RegWrite}, 32'd0);
    chk("t1_idle_rdy", {31'd0, Ready}, 32'd1);
    for (int r = 0; r < 32; r++) read_chk(5'(r), 32'd0, "t1_rd");
    step();

    // 2: single write from A
    ReqA = 1'b1; AddrA = 5'd2; DataA = 32'd42;
    #1;
    chk("t2_gnt", {30'd0, GntA, GntB}, 32'd2);
    step();
    ReqA = 1'b0;
    chk("t2_wr", {27'd0, WriteRegister}, 32'd2);
    chk("t2_wd", WriteData, 32'd42);
    chk("t2_we", {31'd0, RegWrite}, 32'd1);
    step();
    read_chk(5'd2, 32'd42, "t2_rd");
    step();

    // 4: write to register 0 from B is granted but suppressed; pointer moves to A
    ReqB = 1'b1; AddrB = 5'd0; DataB = 32'hFF;
    #1;
    chk("t4_gnt", {30'd0, GntA, GntB}, 32'd1);
    step();
    ReqB = 1'b0;
    chk("t4_we", {31'd0, RegWrite}, 32'd0);
    chk("t4_wr", {27'd0, WriteRegister}, 32'd0);
    chk("t4_wd", WriteData, 32'hFF);
    step();
    read_chk(5'd0, 32'd0, "t4_rd0");
    step();

    // 3: both held, grants alternate starting with A
    ReqA = 1'b1; AddrA = 5'd3; DataA = 32'd15;
    ReqB = 1'b1; AddrB = 5'd4; DataB = 32'hEE;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_gnta", {31'd0, GntA}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_gntb", {31'd0, GntB}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_excl", {31'd0, GntA & GntB}, 32'd0);
      step();
      chk("t3_wr", {27'd0, WriteRegister}, (k % 2 == 0) ? 32'd3 : 32'd4);
      chk("t3_wd", WriteData, (k % 2 == 0) ? 32'd15 : 32'hEE);
      chk("t3_we", {31'd0, RegWrite}, 32'd1);
    end
    ReqA = 1'b0; ReqB = 1'b0;
    step();

    // 5: write reg 7, then ClearReq together with a held ReqA
    ReqA = 1'b1; AddrA = 5'd7; DataA = 32'h1234;
    #1;
    chk("t5_gnt1", {31'd0, GntA}, 32'd1);
    step();
    chk("t5_wr7", {27'd0, WriteRegister}, 32'd7);
    chk("t5_wd7", WriteData, 32'h1234);
    AddrA = 5'd9; DataA = 32'h55; ClearReq = 1'b1;
    #1;
    chk("t5_clr_gnt", {30'd0, GntA, GntB}, 32'd0);
    chk("t5_clr_rdy", {31'd0, Ready}, 32'd1);
    step();
    ClearReq = 1'b0;
    chk("t5_rdy_drop", {31'd0, Ready}, 32'd0);
    chk("t5_we_drop", {31'd0, RegWrite}, 32'd0);
    read_chk(5'd7, 32'h1234, "t5_rd7_pre");
    sweep_chk("t5");
    #1;
    chk("t5_rdy_up", {31'd0, Ready}, 32'd1);
    chk("t5_held_gnt", {31'd0, GntA}, 32'd1);
    step();
    ReqA = 1'b0;
    chk("t5_held_wr", {27'd0, WriteRegister}, 32'd9);
    chk("t5_held_wd", WriteData, 32'h55);
    chk("t5_held_we", {31'd0, RegWrite}, 32'd1);
    read_chk(5'd7, 32'd0, "t5_rd7_post");
    step();

    // 6: asynchronous reset in the middle of a sweep
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    repeat (10) step();
    chk("t6_at10", {27'd0, WriteRegister}, 32'd10);
    Reset_n = 1'b0;
    #1;
    chk("t6_async_we", {31'd0, RegWrite}, 32'd0);
    chk("t6_async_wr", {27'd0, WriteRegister}, 32'd0);
    chk("t6_async_rdy", {31'd0, Ready}, 32'd0);
    step(); step();
    chk("t6_hold_wd", WriteData, 32'd0);
    Reset_n = 1'b1;
    sweep_chk("t6");

    // randomized traffic against the reference model
    for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
    next_is_a = 1'b1;
    cur_wr = 5'd31; cur_wd = 32'd0; cur_we = 1'b1;
    ra = 1'b0; rb = 1'b0;
    aa = 5'd0; ab = 5'd0; da = 32'd0; db = 32'd0;
    for (int n = 0; n < 1200; n++) begin
      clr = ($urandom_range(0, 59) == 0);
      if (ra && $urandom_range(0, 15) == 0) ra = 1'b0;
      else if (!ra) begin
        ra = $urandom_range(0, 1) == 1;
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        da = $urandom;
      end
      if (rb && $urandom_range(0, 15) == 0) rb = 1'b0;
      else if (!rb) begin
        rb = $urandom_range(0, 1) == 1;
        ab = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        db = $urandom;
      end
      ClearReq = clr; ReqA = ra; AddrA = aa; DataA = da; ReqB = rb; AddrB = ab; DataB = db;
      rd_addr1 = 5'($urandom_range(0, 31));
      rd_addr2 = 5'($urandom_range(0, 31));
      #1;
      run = (sweep_q.size() == 0);
      ega = run && !clr && ra && (!rb || next_is_a);
      egb = run && !clr && rb && (!ra || !next_is_a);
      chk("rnd_gnta", {31'd0, GntA}, {31'd0, ega});
      chk("rnd_gntb", {31'd0, GntB}, {31'd0, egb});
      chk("rnd_rdy", {31'd0, Ready}, {31'd0, run});
      chk("rnd_rd1", rd_data1, mem_m[rd_addr1]);
      chk("rnd_rd2", rd_data2, mem_m[rd_addr2]);
      e_wr = cur_wr; e_wd = cur_wd; e_we = 1'b0;
      if (!run) begin
        e_wr = 5'(sweep_q.pop_front()); e_wd = 32'd0; e_we = 1'b1;
      end else if (clr) begin
        sweep_q = {};
        for (int a = 1; a < 32; a++) sweep_q.push_back(a);
      end else if (ega) begin
        e_wr = aa; e_wd = da; e_we = (aa != 5'd0); next_is_a = 1'b0; ra = 1'b0;
      end else if (egb) begin
        e_wr = ab; e_wd = db; e_we = (ab != 5'd0); next_is_a = 1'b1; rb = 1'b0;
      end
      step();
      chk("rnd_wr", {27'd0, WriteRegister}, {27'd0, e_wr});
      chk("rnd_wd", WriteData, e_wd);
      chk("rnd_we", {31'd0, RegWrite}, {31'd0, e_we});
      if (cur_we && cur_wr != 5'd0) mem_m[cur_wr] = cur_wd;
      cur_wr = e_wr; cur_wd = e_wd; cur_we = e_we;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Controller that owns the single write port of the 32x32 two-read/one-write register file (`regfile`).
- After reset, or on request, it sequences a clear of registers 1..31 to zero, one per cycle.
- In normal operation it shares the write port between two requesters (A, B) with round-robin arbitration and a req/gnt handshake.
- All register-file write-port signals are driven from registers inside this block.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- NUM_REGS, 32, number of registers; the clear sweep covers 1..NUM_REGS-1.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- ClearReq  input  1  level; when sampled high in RUN, restarts the clear sweep.
- ReqA  input  1  requester A write request.
- AddrA  input  ADDR_W  requester A target register.
- DataA  input  DATA_W  requester A write data.
- GntA  output  1  combinational grant to A; the transfer occurs on an edge where ReqA&GntA.
- ReqB  input  1  requester B write request.
- AddrB  input  ADDR_W  requester B target register.
- DataB  input  DATA_W  requester B write data.
- GntB  output  1  combinational grant to B; same rule as GntA.
- Ready  output  1  high when state==RUN.
- WriteRegister  output  ADDR_W  to regfile WriteRegister; registered.
- WriteData  output  DATA_W  to regfile WriteData; registered.
- RegWrite  output  1  to regfile RegWrite; registered.

Behaviour:
- Reset (Reset_n low, asynchronous): state=CLEAR, cnt=1, rr_ptr=A, WriteRegister=0, WriteData=0, RegWrite=0. Ready=0, GntA=GntB=0.
- States: CLEAR, RUN.
- CLEAR, each edge:
  - WriteRegister<=cnt, WriteData<=0, RegWrite<=1.
  - If cnt==NUM_REGS-1: state<=RUN, cnt<=1. Otherwise cnt<=cnt+1.
  - The sweep is exactly 31 RegWrite cycles, covering addresses 1..31 in order. Register 0 is never written.
- In CLEAR: GntA=GntB=0, and ClearReq is ignored.
- RUN, priority order:
  - ClearReq=1: state<=CLEAR, cnt<=1, RegWrite<=0 on that edge. No grant is issued in that cycle: GntA=GntB=0 combinationally whenever ClearReq=1.
  - Else only one requester high: grant it.
  - Else both high: grant the one selected by rr_ptr.
  - Else neither: RegWrite<=0; WriteRegister and WriteData hold.
- On a granted edge:
  - WriteRegister<=Addr, WriteData<=Data of the winner.
  - RegWrite<=1, unless Addr==0, in which case RegWrite<=0. The request is still granted and consumed.
  - rr_ptr<= the other requester.
- rr_ptr changes only on a granted edge.
- Latency: a request granted at edge N appears on the write-port signals after edge N; the regfile captures it at edge N+1.
- At most one grant per cycle, giving full throughput of 1 write/cycle. Back-to-back grants to the same requester are allowed when the other is idle.
- Requesters hold Req/Addr/Data stable until granted. Dropping Req before grant is legal and results in no write.
- Reset mid-sweep or mid-transfer: immediate return to the reset values. The pending transfer is lost and the sweep restarts from 1 after Reset_n rises.

Test Plan:
1. Release reset, no requests:
   - 31 consecutive cycles of RegWrite=1 with WriteRegister=1..31 and WriteData=0.
   - Then RegWrite=0 and Ready=1.
   - Regfile reads of regs 0..31 all return 0.
2. RUN, ReqA only with AddrA=2, DataA=42 for one cycle:
   - GntA=1, GntB=0.
   - Next cycle WriteRegister=2, WriteData=42, RegWrite=1.
   - After a further edge, ReadRegister1=2 returns 42.
3. RUN, ReqA (AddrA=3, DataA=15) and ReqB (AddrB=4, DataB=0xEE) held together:
   - Grants alternate A,B,A,B starting with A.
   - Write-port sequence is (3,15),(4,0xEE),(3,15),(4,0xEE).
   - At no time is GntA&GntB=1.
4. RUN, ReqB with AddrB=0, DataB=0xFF:
   - GntB=1 and rr_ptr advances.
   - RegWrite stays 0 and register 0 reads 0.
5. RUN, write 0x1234 to reg 7, then ClearReq=1 for one cycle together with ReqA:
   - GntA=0 in that cycle and Ready drops.
   - Full 31-cycle sweep follows, and reg 7 reads 0 afterwards.
   - After Ready returns, the held ReqA is granted.
6. Assert Reset_n low at sweep address 10 for 2 cycles:
   - Outputs go to reset values immediately, without waiting for Clk.
   - After release, the sweep restarts at address 1 and takes 31 cycles.
